// File: rtl/downcount_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the active-low seven-segment patterns, the timer state enum and
// the BCD digit type used by downcount_timer and bcd_to_seg7.
package downcount_pkg;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Timer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Clamp a non-decimal nibble (A..F) to 9 so the count is always valid BCD
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/downcount_timer_seg7.sv
// Single-digit BCD to active-low seven-segment decoder (combinational).
// A set blank input forces every segment off regardless of the digit.
module bcd_to_seg7
  import downcount_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup; non-decimal codes never reach here but decode to blank
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/downcount_timer.sv
// Multi-digit BCD countdown timer with per-digit seven-segment decode.
// Load captures a (clamped) BCD start value; start/pause control a
// prescaled decrement; reaching zero enters DONE with a one-cycle expired
// pulse. Build macro DOWNCOUNT_BLANK_EN blanks leading-zero digits
// (digit 0 is always shown); count and flags are identical in both builds.
module downcount_timer
  import downcount_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 100000000,
  parameter int DIV_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic                expired_q, expired_d;

  logic [4*DIGITS-1:0] load_clean;
  logic [4*DIGITS-1:0] count_dec;
  logic [DIGITS-1:0]   blank;
  logic                tick;
  logic                count_zero;
  logic                dec_zero;

  // Per-digit clamp of the load value to a legal BCD digit
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
      assign load_clean[gi*4 +: 4] = bcd_clamp(load_val[gi*4 +: 4]);
    end
  endgenerate

  // BCD decrement by one: zero digits roll to 9 and pass the borrow upward
  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    count_dec = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[i*4 +: 4] == 4'd0) begin
          count_dec[i*4 +: 4] = 4'd9;
        end else begin
          count_dec[i*4 +: 4] = count_q[i*4 +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign tick       = (presc_q == TICK_LAST);
  assign count_zero = (count_q == '0);
  assign dec_zero   = (count_dec == '0);

  // State, count, prescaler and expiry pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic; load overrides everything, then pause, then start.
  // The RUN cycle in which pause arrives still advances the prescaler (and
  // may still tick); reaching zero on that tick goes to DONE, not PAUSED.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    if (load) begin
      state_d = IDLE;
      count_d = load_clean;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (!count_zero) begin
              state_d = RUN;
              presc_d = '0;
            end else begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
            count_d = count_dec;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
          if (tick && dec_zero) begin
            state_d   = DONE;
            expired_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Flags and count are straight decodes of the registered state
  always_comb begin
    running   = (state_q == RUN);
    done      = (state_q == DONE);
    expired   = expired_q;
    count_bcd = count_q;
  end

`ifdef DOWNCOUNT_BLANK_EN
  // Blank digits above digit 0 while every digit from the top down is zero
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (count_q[i*4 +: 4] == 4'd0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  // One decoder per digit, driven directly from the registered count
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      bcd_to_seg7 u_dec (
        .digit (count_q[gi*4 +: 4]),
        .blank (blank[gi]),
        .seg   (seg[gi*7 +: 7])
      );
    end
  endgenerate

endmodule

// File: tb/tb_downcount_timer.sv
// Scoreboard testbench for downcount_timer (DIGITS=2, TICK_DIV=4).
// Each driven cycle pushes the expected post-edge outputs from a decimal
// reference model; the monitor pops and compares after the edge.
module tb_downcount_timer;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
  logic                start = 1'b0;
  logic                pause = 1'b0;
  logic [4*DIGITS-1:0] count_bcd;
  logic [7*DIGITS-1:0] seg;
  logic                running;
  logic                done;
  logic                expired;

  downcount_timer #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .count_bcd (count_bcd),
    .seg       (seg),
    .running   (running),
    .done      (done),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef DOWNCOUNT_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

  typedef struct {
    logic [4*DIGITS-1:0] cnt;
    logic [7*DIGITS-1:0] sg;
    logic                run;
    logic                dn;
    logic                ex;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: 0 idle, 1 run, 2 paused, 3 done; count kept in decimal
  int m_st  = 0;
  int m_cnt = 0;
  int m_pr  = 0;
  bit m_ex  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  function automatic int sanitize(input logic [4*DIGITS-1:0] v);
    int n = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      n += d * w;
      w *= 10;
    end
    return n;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] v = '0;
    int r = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input int n);
    logic [4*DIGITS-1:0] v = to_bcd(n);
    logic [7*DIGITS-1:0] s = '0;
    bit lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      logic [3:0] d = v[i*4 +: 4];
      lead = lead && (d == 4'd0);
`ifdef DOWNCOUNT_BLANK_EN
      s[i*7 +: 7] = (lead && i > 0) ? BLANK : SEGTAB[d];
`else
      s[i*7 +: 7] = SEGTAB[d];
`endif
    end
    return s;
  endfunction

  task automatic model_update(input bit r, input bit l, input logic [4*DIGITS-1:0] lv,
                              input bit s, input bit p);
    bit ex_n = 1'b0;
    if (!r) begin
      m_st = 0; m_cnt = 0; m_pr = 0; m_ex = 1'b0;
    end else begin
      if (l) begin
        m_st = 0; m_cnt = sanitize(lv); m_pr = 0;
      end else begin
        case (m_st)
          0: if (s) begin
               if (m_cnt != 0) begin m_st = 1; m_pr = 0; end
               else begin m_st = 3; ex_n = 1'b1; end
             end
          1: begin
               if (m_pr == TICK_DIV - 1) begin m_pr = 0; m_cnt = m_cnt - 1; end
               else m_pr = m_pr + 1;
               if (m_cnt == 0) begin m_st = 3; ex_n = 1'b1; end
               else if (p) m_st = 2;
             end
          2: if (s && !p) m_st = 1;
          default: ;
        endcase
      end
      m_ex = ex_n;
    end
  endtask

  // Drive one cycle, predict, then compare after the edge
  task automatic step(input bit r, input bit l, input logic [4*DIGITS-1:0] lv,
                      input bit s, input bit p);
    exp_t e;
    @(negedge clk);
    rst_n = r; load = l; load_val = lv; start = s; pause = p;
    model_update(r, l, lv, s, p);
    e.cnt = to_bcd(m_cnt);
    e.sg  = exp_seg(m_cnt);
    e.run = (m_st == 1);
    e.dn  = (m_st == 3);
    e.ex  = m_ex;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_count", 32'(count_bcd), 32'(e.cnt));
    check_eq("sb_seg", 32'(seg), 32'(e.sg));
    check_eq("sb_running", 32'(running), 32'(e.run));
    check_eq("sb_done", 32'(done), 32'(e.dn));
    check_eq("sb_expired", 32'(expired), 32'(e.ex));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("rst_count", 32'(count_bcd), 32'h0);
    check_eq("rst_seg", 32'(seg), 32'({HI_ZERO, 7'b1000000}));
    check_eq("rst_flags", 32'({running, done, expired}), 32'h0);

    // Basic count with borrow
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(4);
    check_eq("t1_cnt11", 32'(count_bcd), 32'h11);
    idle(4);
    check_eq("t1_cnt10", 32'(count_bcd), 32'h10);
    idle(4);
    check_eq("t1_cnt09", 32'(count_bcd), 32'h09);
    check_eq("t1_seg09", 32'(seg), 32'({HI_ZERO, 7'b0010000}));

    // Expiry
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(8);
    check_eq("t2_cnt0", 32'(count_bcd), 32'h0);
    check_eq("t2_done_run_exp", 32'({done, running, expired}), 32'b101);
    idle(1);
    check_eq("t2_exp_once", 32'(expired), 32'h0);
    idle(5);
    check_eq("t2_hold", 32'({count_bcd, done, expired}), 32'({8'h00, 1'b1, 1'b0}));

    // Pause and resume
    step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    idle(20);
    check_eq("t3_paused_cnt", 32'(count_bcd), 32'h05);
    check_eq("t3_paused_run", 32'(running), 32'h0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check_eq("t3_resume_hold", 32'(count_bcd), 32'h05);
    idle(1);
    check_eq("t3_resume_dec", 32'(count_bcd), 32'h04);

    // Priority and sanitising
    step(1'b1, 1'b1, 8'h34, 1'b1, 1'b0);
    check_eq("t4_load_start", 32'({count_bcd, running}), 32'({8'h34, 1'b0}));
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check_eq("t4_pause_wins", 32'(running), 32'h0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check_eq("t4_paused_stays", 32'(running), 32'h0);
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    check_eq("t4_clamp", 32'(count_bcd), 32'h39);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_eq("t4_start_zero", 32'({done, expired}), 32'b11);

    // Mid-run reset and reload from DONE
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("t5_rst_cnt", 32'(count_bcd), 32'h0);
    check_eq("t5_rst_flags", 32'({running, done, expired}), 32'h0);
    idle(6);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
    check_eq("t5_reload", 32'({count_bcd, done}), 32'({8'h07, 1'b0}));
    check_eq("t5_seg07", 32'(seg), 32'({HI_ZERO, 7'b1111000}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
